// File: rtl/seq_cmp_pkg.sv
// Shared types and helpers for the round-robin scheduler in front of the
// bit-serial unsigned comparator.
package seq_cmp_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 2;
  localparam int DEF_IDW   = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    READ,
    CAPTURE,
    RESP
  } state_e;

  // True when exactly one of the three comparator flags is set.
  function automatic logic onehot3(input logic l, input logic e, input logic g);
    return (l & ~e & ~g) | (~l & e & ~g) | (~l & ~e & g);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr+1 (with
// wrap) wins. The pointer register belongs to the caller.
module rr_arbiter
  import seq_cmp_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_any
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop, so no path
    // leaves a signal unassigned and no latch is inferred.
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[idx]) begin
        o_any       = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/seq_cmp_scheduler.sv
// Shares one bit-serial unsigned comparator between NREQ requesters:
// arbitrate, load, shift WIDTH cycles, read, capture and return a tagged result.
module seq_cmp_scheduler
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = DEF_IDW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_lt,
  output logic                  rsp_eq,
  output logic                  rsp_gt,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  output logic                  cmp_ip,
  output logic                  cmp_op,
  input  logic                  cmp_l,
  input  logic                  cmp_e,
  input  logic                  cmp_g
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_ip, r_op, r_busy;
  logic             r_rsp_valid, r_lt, r_eq, r_gt, r_err;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_any;
  logic             w_accept;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Grants are only offered from IDLE; reset masks them so nothing is
  // accepted on a reset edge.
  assign w_accept  = (r_state == IDLE) && !rst && w_any;
  assign req_ready = w_accept ? w_grant : '0;

  always_ff @(posedge clk) begin
    // NOTE: state and outputs are updated with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_cnt       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ip        <= 1'b0;
      r_op        <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_a     <= req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
          r_b     <= req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
          r_id    <= w_grant_idx;
          r_ptr   <= w_grant_idx;
          r_ip    <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: begin
          r_ip    <= 1'b0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          // The counter is one bit wider than needed so it stops at WIDTH.
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_op    <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          r_op    <= 1'b0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_lt        <= cmp_l;
          r_eq        <= cmp_e;
          r_gt        <= cmp_g;
          r_err       <= ~onehot3(cmp_l, cmp_e, cmp_g);
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_lt    = r_lt;
  assign rsp_eq    = r_eq;
  assign rsp_gt    = r_gt;
  assign rsp_err   = r_err;
  assign busy      = r_busy;
  assign cmp_a     = r_a;
  assign cmp_b     = r_b;
  assign cmp_ip    = r_ip;
  assign cmp_op    = r_op;

endmodule

// File: tb/tb_seq_cmp_scheduler.sv
// Scoreboard bench for seq_cmp_scheduler with a behavioural comparator stub
// and a transaction-level model of arbitration and timing.
`timescale 1ns/1ps
module tb_seq_cmp_scheduler;
  import seq_cmp_pkg::*;

  localparam int W    = 32;
  localparam int NREQ = 3;
  localparam int IDW  = 3;
  localparam int LAT  = W + 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*W-1:0]    req_a, req_b;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_lt, rsp_eq, rsp_gt, rsp_err, busy;
  logic [W-1:0]         cmp_a, cmp_b;
  logic                 cmp_ip, cmp_op;
  logic                 cmp_l, cmp_e, cmp_g;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  seq_cmp_scheduler #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_err(rsp_err),
    .busy(busy), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_ip(cmp_ip), .cmp_op(cmp_op),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Comparator stand-in: latches operands on ip, counts shift cycles, and on
  // op reports the result only if exactly W shifts happened with stable operands.
  logic [W-1:0] st_a, st_b;
  int           st_cnt;
  logic         stub_force = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      {cmp_l, cmp_e, cmp_g} <= 3'b000;
      st_a <= '0; st_b <= '0; st_cnt <= 0;
    end else if (cmp_ip) begin
      st_a <= cmp_a; st_b <= cmp_b; st_cnt <= 0;
    end else if (cmp_op) begin
      if (stub_force)
        {cmp_l, cmp_e, cmp_g} <= 3'b110;
      else if (st_cnt == W && st_a == cmp_a && st_b == cmp_b)
        {cmp_l, cmp_e, cmp_g} <= {st_a < st_b, st_a == st_b, st_a > st_b};
      else
        {cmp_l, cmp_e, cmp_g} <= 3'b000;
    end else begin
      st_cnt <= st_cnt + 1;
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    int         id;
    logic       lt, eq, gt, err;
    logic [W-1:0] a, b;
    int         acc;
  } exp_t;

  exp_t            q[$];
  exp_t            cur, fl, e_new;
  bit              inflight = 0;
  bit              rsp_open = 0;
  int              model_ptr = NREQ - 1;
  logic [NREQ-1:0] acc_mask = '0;
  logic [NREQ-1:0] g_exp;
  int              w_m, k_m;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    acc_mask = req_ready & req_valid;
    if (rst) begin
      q.delete();
      inflight  = 0;
      rsp_open  = 0;
      model_ptr = NREQ - 1;
    end else begin
      check("ready_onehot0", $onehot0(req_ready), 1);
      if (inflight) begin
        k_m = cyc - fl.acc;
        check("busy_active", busy, 1);
        check("ready_while_busy", req_ready, 0);
        check("cmp_ip_pulse", cmp_ip, k_m == 0);
        check("cmp_op_pulse", cmp_op, k_m == W + 1);
        if (k_m <= W + 1) begin
          check("cmp_a_hold", cmp_a, fl.a);
          check("cmp_b_hold", cmp_b, fl.b);
        end
        check("rsp_valid_timing", rsp_valid, k_m >= LAT);
        if (rsp_valid && !rsp_open) begin
          if (q.size() == 0) check("rsp_without_expect", 0, 1);
          else begin
            cur = q.pop_front();
            rsp_open = 1;
          end
        end
        if (rsp_valid && rsp_open) begin
          check("rsp_id", rsp_id, cur.id);
          check("rsp_lt", rsp_lt, cur.lt);
          check("rsp_eq", rsp_eq, cur.eq);
          check("rsp_gt", rsp_gt, cur.gt);
          check("rsp_err", rsp_err, cur.err);
        end
        if (rsp_valid && rsp_ready) begin
          inflight = 0;
          rsp_open = 0;
        end
      end else begin
        check("busy_idle", busy, 0);
        check("rsp_valid_idle", rsp_valid, 0);
        check("cmp_ip_idle", cmp_ip, 0);
        check("cmp_op_idle", cmp_op, 0);
        w_m   = rr_pick(req_valid, model_ptr);
        g_exp = '0;
        if (w_m >= 0) g_exp[w_m] = 1'b1;
        check("grant", req_ready, g_exp);
        if (w_m >= 0) begin
          e_new.id  = w_m;
          e_new.a   = req_a[w_m*W +: W];
          e_new.b   = req_b[w_m*W +: W];
          e_new.acc = cyc + 1;
          if (stub_force) begin
            e_new.lt = 1; e_new.eq = 1; e_new.gt = 0; e_new.err = 1;
          end else begin
            e_new.lt  = e_new.a < e_new.b;
            e_new.eq  = e_new.a == e_new.b;
            e_new.gt  = e_new.a > e_new.b;
            e_new.err = 0;
          end
          q.push_back(e_new);
          fl        = e_new;
          inflight  = 1;
          model_ptr = w_m;
        end
      end
    end
  end

  // Stimulus helpers.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] pick_b(input logic [W-1:0] a);
    case ($urandom_range(0, 5))
      0:       return a;
      1:       return a + 1;
      2:       return a - 1;
      3:       return '0;
      4:       return '1;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 0;
    set_req(i, a, b);
    req_valid[i] = 1'b1;
    for (int t = 0; t < 400 && !got; t++) begin
      step();
      if (acc_mask[i]) got = 1;
    end
    req_valid[i] = 1'b0;
    check("issue_accepted", got, 1);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 3000; t++) begin
      if (!inflight && !rsp_open && q.size() == 0) break;
      step();
    end
    check("drain_in_time", t < 3000, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_flags"}, {rsp_lt, rsp_eq, rsp_gt, rsp_err}, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_cmp_strobes"}, {cmp_ip, cmp_op}, 0);
    check({tag, "_cmp_a"}, cmp_a, 0);
    check({tag, "_cmp_b"}, cmp_b, 0);
  endtask

  initial begin
    int n, prev, t;
    logic [W-1:0] ra;

    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    check_reset_outs("reset");
    rst = 1'b0;

    // Basic equal, less-than and unsigned greater-than compares.
    issue(0, 32'd50, 32'd50);
    wait_idle();
    issue(1, 32'h0000_0000, 32'hFFFF_FFFF);
    wait_idle();
    issue(0, 32'h8000_0000, 32'h7FFF_FFFF);
    wait_idle();

    // Two requesters held valid continuously must alternate.
    set_req(0, $urandom, $urandom);
    set_req(1, $urandom, $urandom);
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    n = 0; prev = -1;
    for (t = 0; t < 1000 && n < 4; t++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (acc_mask[i]) begin
          if (prev >= 0) check("alternate_order", i, 1 - prev);
          prev = i;
          n++;
          ra = $urandom;
          set_req(i, ra, pick_b(ra));
        end
      end
    end
    check("alternate_count", n, 4);
    req_valid = '0;
    wait_idle();

    // Backpressure: response held, no grants, then exactly one bubble cycle.
    rsp_ready = 1'b0;
    issue(0, 32'h1234, 32'h1234);
    set_req(1, 32'd7, 32'd3);
    req_valid[1] = 1'b1;
    for (t = 0; t < 100 && !rsp_valid; t++) step();
    check("bp_rsp_seen", rsp_valid, 1);
    repeat (5) begin
      step();
      check("bp_busy", busy, 1);
      check("bp_ready_held", req_ready, 0);
      check("bp_valid_held", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_bubble_busy", busy, 0);
    check("bp_bubble_grant", req_ready, 3'b010);
    step();
    check("bp_next_accept", acc_mask, 3'b010);
    req_valid[1] = 1'b0;
    wait_idle();

    // Reset in the middle of SHIFT discards the request and rewinds the pointer.
    issue(0, 32'd100, 32'd200);
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outs("midrst");
    repeat (4) step();
    check("midrst_no_rsp", rsp_valid, 0);
    set_req(0, 32'd9, 32'd4);
    set_req(1, 32'd4, 32'd9);
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    for (t = 0; t < 50 && acc_mask == 0; t++) step();
    check("midrst_first_winner", acc_mask, 3'b001);
    req_valid = '0;
    wait_idle();

    // Comparator reporting two flags at once.
    stub_force = 1'b1;
    issue(1, 32'd5, 32'd9);
    wait_idle();
    stub_force = 1'b0;

    // Randomised traffic with backpressure and occasional withdrawn requests.
    n = 0;
    for (t = 0; t < 6000 && n < 40; t++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && acc_mask[i]) begin
          req_valid[i] = 1'b0;
          n++;
        end
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            ra = $urandom;
            set_req(i, ra, pick_b(ra));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 40) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    check("random_progress", n >= 40, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
